// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the FSM state encoding, reset/NOP defaults and the decoder opcode constants.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

  localparam logic [6:0] OPC_ITYPE = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: word-aligned redirect load has priority over +4 advance.
// The increment wraps naturally modulo 2^32.
module pc_reg
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = {load_pc_i[31:2], 2'b00};
    end else if (inc_i) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: IDLE -> FETCH (request until ack) -> VALID (hold until not stalled).
// A redirect from FETCH or VALID squashes the held word to a NOP and restarts fetching at the new target.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] instr_o,
  output logic [6:0]  opcode_o,
  output logic        instr_valid_o
);

  fetch_state_e state_q;
  fetch_state_e state_d;
  logic [31:0]  instr_q;
  logic [31:0]  instr_d;
  logic         redirect_en;
  logic         pc_inc;

  // A redirect only counts once the unit has left IDLE.
  assign redirect_en = redirect_i && (state_q != ST_IDLE);
  assign pc_inc      = (state_q == ST_VALID) && !stall_i && !redirect_en;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: begin
        if (redirect_en) begin
          state_d = ST_FETCH;
        end else if (imem_ack_i) begin
          state_d = ST_VALID;
        end
      end
      ST_VALID: begin
        if (redirect_en || !stall_i) begin
          state_d = ST_FETCH;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req_o    = 1'b0;
    instr_valid_o = 1'b0;
    case (state_q)
      ST_FETCH: imem_req_o    = 1'b1;
      ST_VALID: instr_valid_o = 1'b1;
      default: begin
        imem_req_o    = 1'b0;
        instr_valid_o = 1'b0;
      end
    endcase
  end

  // Ack data arriving alongside a redirect belongs to the squashed address and is dropped.
  always_comb begin
    instr_d = instr_q;
    if (redirect_en) begin
      instr_d = NOP_INSTR;
    end else if ((state_q == ST_FETCH) && imem_ack_i) begin
      instr_d = imem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q <= NOP_INSTR;
    end else begin
      instr_q <= instr_d;
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .inc_i     (pc_inc),
    .load_i    (redirect_en),
    .load_pc_i (redirect_pc_i),
    .pc_o      (pc_o)
  );

  assign imem_addr_o = pc_o;
  assign instr_o     = instr_q;
  assign opcode_o    = instr_q[6:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared against a behavioural model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] WPC  = 32'hFFFF_FFFC;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic [6:0]  opcode_o;
  logic        instr_valid_o;

  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [6:0]  w_opcode;
  logic        w_valid;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: "booting" is the one cycle after reset, "holding" means a valid word is held.
  bit          m_booting;
  bit          m_holding;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  always #5 clk_i = ~clk_i;

  fetch_unit u_dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (pc_o),
    .instr_o       (instr_o),
    .opcode_o      (opcode_o),
    .instr_valid_o (instr_valid_o)
  );

  fetch_unit #(.RESET_PC(WPC)) u_wrap (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (w_req),
    .imem_addr_o   (w_addr),
    .imem_ack_i    (imem_ack_i),
    .imem_rdata_i  (imem_rdata_i),
    .pc_o          (w_pc),
    .instr_o       (w_instr),
    .opcode_o      (w_opcode),
    .instr_valid_o (w_valid)
  );

  task automatic model_reset();
    m_booting = 1'b1;
    m_holding = 1'b0;
    m_pc      = 32'h0;
    m_instr   = NOP;
  endtask

  task automatic model_step();
    if (m_booting) begin
      m_booting = 1'b0;
    end else if (redirect_i) begin
      m_pc      = redirect_pc_i & 32'hFFFF_FFFC;
      m_instr   = NOP;
      m_holding = 1'b0;
    end else if (m_holding) begin
      if (!stall_i) begin
        m_pc      = m_pc + 32'd4;
        m_holding = 1'b0;
      end
    end else if (imem_ack_i) begin
      m_instr   = imem_rdata_i;
      m_holding = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    imem_ack_i = 1'b0; imem_rdata_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl: req=%b valid=%b, want 0 0", imem_req_o, instr_valid_o);
    end
    n_tests++;
    if (pc_o !== 32'h0 || instr_o !== NOP || opcode_o !== 7'h13) begin
      n_fail++; $display("FAIL reset_data: pc=%h instr=%h opc=%h, want 0 %h 13", pc_o, instr_o, opcode_o, NOP);
    end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0800;
    tick();
    redirect_i = 1'b0;
    n_tests++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_exit: req=%b addr=%h valid=%b, want 1 0 0", imem_req_o, imem_addr_o, instr_valid_o);
    end
  endtask

  task automatic test_basic();
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0050_0093;
    tick();
    n_tests++;
    if (instr_valid_o !== 1'b1 || imem_req_o !== 1'b0 || pc_o !== 32'h0 || opcode_o !== 7'b0010011) begin
      n_fail++; $display("FAIL basic_first: valid=%b req=%b pc=%h opc=%b, want 1 0 0 0010011", instr_valid_o, imem_req_o, pc_o, opcode_o);
    end
    imem_rdata_i = 32'h0020_81B3;
    tick();
    n_tests++;
    if (instr_valid_o !== 1'b0 || imem_req_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== 32'h0050_0093) begin
      n_fail++; $display("FAIL basic_gap: valid=%b req=%b pc=%h instr=%h, want 0 1 4 00500093", instr_valid_o, imem_req_o, pc_o, instr_o);
    end
    tick();
    n_tests++;
    if (instr_valid_o !== 1'b1 || pc_o !== 32'h4 || opcode_o !== 7'b0110011 || instr_o !== 32'h0020_81B3) begin
      n_fail++; $display("FAIL basic_second: valid=%b pc=%h opc=%b instr=%h, want 1 4 0110011 002081b3", instr_valid_o, pc_o, opcode_o, instr_o);
    end
    imem_ack_i = 1'b0;
  endtask

  task automatic test_delayed_ack();
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
        n_fail++; $display("FAIL delayed_hold[%0d]: req=%b addr=%h valid=%b, want 1 0 0", i, imem_req_o, imem_addr_o, instr_valid_o);
      end
      imem_ack_i = (i == 3);
      imem_rdata_i = 32'h1234_5613;
      tick();
    end
    imem_ack_i = 1'b0;
    n_tests++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h1234_5613) begin
      n_fail++; $display("FAIL delayed_valid: valid=%b instr=%h, want 1 12345613", instr_valid_o, instr_o);
    end
  endtask

  task automatic test_stall();
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      imem_ack_i = 1'b1; imem_rdata_i = $urandom;
      tick();
      n_tests++;
      if (pc_o !== 32'h0 || instr_o !== 32'h1234_5613 || imem_req_o !== 1'b0 || instr_valid_o !== 1'b1) begin
        n_fail++; $display("FAIL stall_hold[%0d]: pc=%h instr=%h req=%b valid=%b, want 0 12345613 0 1", i, pc_o, instr_o, imem_req_o, instr_valid_o);
      end
    end
    stall_i = 1'b0; imem_ack_i = 1'b0;
    tick();
    n_tests++;
    if (pc_o !== 32'h4 || imem_req_o !== 1'b1 || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: pc=%h req=%b valid=%b, want 4 1 0", pc_o, imem_req_o, instr_valid_o);
    end
  endtask

  task automatic test_redirect();
    imem_ack_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    tick();
    idle_inputs();
    n_tests++;
    if (instr_o !== NOP || pc_o !== 32'h0000_0100 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0000_0100 || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL redirect_ack: instr=%h pc=%h req=%b addr=%h valid=%b, want %h 100 1 100 0", instr_o, pc_o, imem_req_o, imem_addr_o, instr_valid_o, NOP);
    end
  endtask

  task automatic test_async_reset();
    imem_ack_i = 1'b0;
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (pc_o !== 32'h0 || instr_o !== NOP || imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset: pc=%h instr=%h req=%b valid=%b, want 0 %h 0 0", pc_o, instr_o, imem_req_o, instr_valid_o, NOP);
    end
    #2 rst_i = 1'b0;
    imem_ack_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    tick();
    imem_ack_i = 1'b0;
    n_tests++;
    if (instr_valid_o !== 1'b0 || instr_o !== NOP || imem_req_o !== 1'b1) begin
      n_fail++; $display("FAIL late_ack: valid=%b instr=%h req=%b, want 0 %h 1", instr_valid_o, instr_o, imem_req_o, NOP);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    tick();
    imem_ack_i = 1'b1; imem_rdata_i = 32'h0000_0013;
    tick();
    imem_ack_i = 1'b0; stall_i = 1'b1;
    n_tests++;
    if (w_pc !== WPC || w_valid !== 1'b1 || w_addr !== WPC) begin
      n_fail++; $display("FAIL wrap_fetch: pc=%h valid=%b addr=%h, want fffffffc 1 fffffffc", w_pc, w_valid, w_addr);
    end
    tick();
    stall_i = 1'b0;
    tick();
    n_tests++;
    if (w_pc !== 32'h0 || w_req !== 1'b1 || w_valid !== 1'b0 || w_instr !== 32'h13 || w_opcode !== 7'h13) begin
      n_fail++; $display("FAIL wrap_pc: pc=%h req=%b valid=%b instr=%h, want 0 1 0 13", w_pc, w_req, w_valid, w_instr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall_i       = ($urandom_range(0, 2) == 0);
      redirect_i    = ($urandom_range(0, 7) == 0);
      redirect_pc_i = $urandom;
      imem_ack_i    = $urandom_range(0, 1);
      imem_rdata_i  = $urandom;
      tick();
      n_tests++;
      if (imem_req_o !== (!m_booting && !m_holding) || instr_valid_o !== m_holding) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: req=%b valid=%b, want %b %b", i, imem_req_o, instr_valid_o, !m_booting && !m_holding, m_holding);
      end
      n_tests++;
      if (pc_o !== m_pc || imem_addr_o !== m_pc) begin
        n_fail++; $display("FAIL rand_pc[%0d]: pc=%h addr=%h, want %h", i, pc_o, imem_addr_o, m_pc);
      end
      n_tests++;
      if (instr_o !== m_instr || opcode_o !== m_instr[6:0]) begin
        n_fail++; $display("FAIL rand_instr[%0d]: instr=%h opc=%h, want %h", i, instr_o, opcode_o, m_instr);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delayed_ack();
    test_stall();
    test_redirect();
    test_async_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
